// File: rtl/pair_triple_pkg.sv
// Shared types and default constants for the pair/triple run tracker.
package pair_triple_pkg;

    // Tracker states: waiting for a detection, inside a run, run at/over threshold
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_RUN_W  = 4;
    localparam int DEF_THRESH = 3;

endpackage

// File: rtl/pair_triple_sat_counter.sv
// Saturating up-counter with synchronous clear; used for event and run-length counts.
module pair_triple_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until the all-ones ceiling
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pair_triple_run_tracker.sv
// Tracks runs of the 2-of-3 detector output: counts rising edges, measures the
// current high run and raises alarm once the run reaches THRESH.
// Optional build macro PAIR_TRIPLE_RUN_TRACKER_STICKY_ALARM_EN makes alarm
// latch until reset or clear.
module pair_triple_run_tracker
    import pair_triple_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int RUN_W  = DEF_RUN_W,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             in_det,
    input  logic             clear,
    output logic [CNT_W-1:0] event_count,
    output logic [RUN_W-1:0] run_len,
    output logic             rise,
    output logic             alarm
);

    // A threshold of zero or beyond the run counter's reach could never be met
    generate
        if ((THRESH < 1) || (THRESH > (2 ** RUN_W) - 1)) begin : g_bad_thresh
            $error("pair_triple_run_tracker: THRESH out of range 1..2^RUN_W-1");
        end
    endgenerate

    localparam logic [RUN_W:0] THRESH_V = (RUN_W + 1)'(THRESH);

    state_t           state_q, state_d;
    logic             rise_q, rise_d;
    logic             alarm_q, alarm_d;
    logic             ev_inc;
    logic             run_inc;
    logic             run_clr;
    logic [RUN_W-1:0] run_len_w;
    logic [RUN_W:0]   run_next;

    // Run length after this sample, one bit wider so the threshold compare is exact
    assign run_next = {1'b0, run_len_w} + (RUN_W + 1)'(1);

    // Next-state, counter control and next rise/alarm values
    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        ev_inc  = 1'b0;
        run_inc = 1'b0;
        run_clr = clear;
        if (clear) begin
            state_d = IDLE;
        end else if (in_val) begin
            if (in_det) begin
                run_inc = 1'b1;
                case (state_q)
                    IDLE: begin
                        rise_d  = 1'b1;
                        ev_inc  = 1'b1;
                        state_d = (THRESH == 1) ? ALARM : RUN;
                    end
                    RUN: begin
                        if (run_next == THRESH_V) begin
                            state_d = ALARM;
                        end
                    end
                    ALARM: begin
                        state_d = ALARM;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end else begin
                state_d = IDLE;
                run_clr = 1'b1;
            end
        end
`ifdef PAIR_TRIPLE_RUN_TRACKER_STICKY_ALARM_EN
        alarm_d = clear ? 1'b0 : (alarm_q || (state_d == ALARM));
`else
        alarm_d = (state_d == ALARM);
`endif
    end

    // State, rise and alarm registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rise_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            alarm_q <= alarm_d;
        end
    end

    pair_triple_sat_counter #(.W(CNT_W)) u_event_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (ev_inc),
        .count (event_count)
    );

    pair_triple_sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .inc   (run_inc),
        .count (run_len_w)
    );

    assign run_len = run_len_w;
    assign rise    = rise_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_pair_triple_run_tracker.sv
// Self-checking bench for pair_triple_run_tracker: two instances (THRESH=3 and
// THRESH=1) share one stimulus stream; a behavioural model pushes expected
// outputs to a queue that is drained after each clock edge.
module tb_pair_triple_run_tracker;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       in_val = 1'b0;
    logic       in_det = 1'b0;
    logic       clear  = 1'b0;

    logic [7:0] ec_a, ec_b;
    logic [3:0] rl_a, rl_b;
    logic       rise_a, rise_b;
    logic       alarm_a, alarm_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ec;
        int rl;
        int rise;
        int alarm;
    } exp_t;

    exp_t exp_q[$];

    // Model state per instance: index 0 is THRESH=3, index 1 is THRESH=1
    int m_thr[2]   = '{3, 1};
    int m_state[2] = '{0, 0};
    int m_ec[2]    = '{0, 0};
    int m_rl[2]    = '{0, 0};
    int m_rise[2]  = '{0, 0};
    int m_alarm[2] = '{0, 0};

    // Free-running clock
    always #5 clk = ~clk;

    pair_triple_run_tracker #(.CNT_W(8), .RUN_W(4), .THRESH(3)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_det      (in_det),
        .clear       (clear),
        .event_count (ec_a),
        .run_len     (rl_a),
        .rise        (rise_a),
        .alarm       (alarm_a)
    );

    pair_triple_run_tracker #(.CNT_W(8), .RUN_W(4), .THRESH(1)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .in_val      (in_val),
        .in_det      (in_det),
        .clear       (clear),
        .event_count (ec_b),
        .run_len     (rl_b),
        .rise        (rise_b),
        .alarm       (alarm_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Behavioural reference: what the outputs should show after this sample
    task automatic modelStep(input int i, input bit rst, input bit clr, input bit val, input bit det);
        if (rst || clr) begin
            m_state[i] = 0; m_ec[i] = 0; m_rl[i] = 0; m_rise[i] = 0; m_alarm[i] = 0;
        end else if (!val) begin
            m_rise[i] = 0;
        end else if (det) begin
            m_rise[i] = (m_state[i] == 0) ? 1 : 0;
            if (m_rise[i] == 1 && m_ec[i] < 255) m_ec[i] = m_ec[i] + 1;
            if (m_rl[i] < 15) m_rl[i] = m_rl[i] + 1;
            if (m_rl[i] >= m_thr[i]) begin
                m_state[i] = 2;
                m_alarm[i] = 1;
            end else begin
                m_state[i] = 1;
            end
        end else begin
            m_state[i] = 0;
            m_rl[i]    = 0;
            m_rise[i]  = 0;
`ifndef PAIR_TRIPLE_RUN_TRACKER_STICKY_ALARM_EN
            m_alarm[i] = 0;
`endif
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit clr, input bit val, input bit det, input string tag);
        exp_t e;
        reset  = rst;
        clear  = clr;
        in_val = val;
        in_det = det;
        for (int i = 0; i < 2; i++) begin
            modelStep(i, rst, clr, val, det);
            e.ec = m_ec[i]; e.rl = m_rl[i]; e.rise = m_rise[i]; e.alarm = m_alarm[i];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput({tag, "/a.ec"},    32'(ec_a),    e.ec);
        checkOutput({tag, "/a.rl"},    32'(rl_a),    e.rl);
        checkOutput({tag, "/a.rise"},  32'(rise_a),  e.rise);
        checkOutput({tag, "/a.alarm"}, 32'(alarm_a), e.alarm);
        e = exp_q.pop_front();
        checkOutput({tag, "/b.ec"},    32'(ec_b),    e.ec);
        checkOutput({tag, "/b.rl"},    32'(rl_b),    e.rl);
        checkOutput({tag, "/b.rise"},  32'(rise_b),  e.rise);
        checkOutput({tag, "/b.alarm"}, 32'(alarm_b), e.alarm);
        @(negedge clk);
    endtask

    // Test sequence
    initial begin
        int sticky;
`ifdef PAIR_TRIPLE_RUN_TRACKER_STICKY_ALARM_EN
        sticky = 1;
`else
        sticky = 0;
`endif
        @(negedge clk);

        // Reset for two cycles
        applyStimulus(1, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, "reset1");
        checkOutput("reset_ec", 32'(ec_a), 0);
        checkOutput("reset_alarm", 32'(alarm_a), 0);

        // Basic run 0,1,1,0
        applyStimulus(0, 0, 1, 0, "t1_s0");
        applyStimulus(0, 0, 1, 1, "t1_s1");
        checkOutput("t1_rise", 32'(rise_a), 1);
        checkOutput("t1_rl1", 32'(rl_a), 1);
        checkOutput("t6_rise", 32'(rise_b), 1);
        checkOutput("t6_alarm", 32'(alarm_b), 1);
        checkOutput("t6_rl", 32'(rl_b), 1);
        applyStimulus(0, 0, 1, 1, "t1_s2");
        checkOutput("t1_rise_low", 32'(rise_a), 0);
        applyStimulus(0, 0, 1, 0, "t1_s3");
        checkOutput("t1_ec", 32'(ec_a), 1);
        checkOutput("t1_rl0", 32'(rl_a), 0);
        checkOutput("t1_alarm", 32'(alarm_a), 0);

        // Run reaching threshold: 1,1,1,1,0
        applyStimulus(0, 0, 1, 1, "t2_s0");
        applyStimulus(0, 0, 1, 1, "t2_s1");
        checkOutput("t2_no_alarm", 32'(alarm_a), 0);
        applyStimulus(0, 0, 1, 1, "t2_s2");
        checkOutput("t2_alarm", 32'(alarm_a), 1);
        checkOutput("t2_rl3", 32'(rl_a), 3);
        applyStimulus(0, 0, 1, 1, "t2_s3");
        checkOutput("t2_rl4", 32'(rl_a), 4);
        applyStimulus(0, 0, 1, 0, "t2_s4");
        checkOutput("t2_alarm_after", 32'(alarm_a), 32'(sticky));
        checkOutput("t2_rl_after", 32'(rl_a), 0);

        // Valid gap does not break a run
        applyStimulus(0, 1, 0, 0, "t3_clr");
        applyStimulus(0, 0, 1, 1, "t3_s0");
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, "t3_gap");
        applyStimulus(0, 0, 1, 1, "t3_s1");
        checkOutput("t3_no_alarm", 32'(alarm_a), 0);
        applyStimulus(0, 0, 1, 1, "t3_s2");
        checkOutput("t3_alarm", 32'(alarm_a), 1);
        checkOutput("t3_ec", 32'(ec_a), 1);
        checkOutput("t3_rl", 32'(rl_a), 3);

        // Clear in ALARM drops the simultaneous sample
        applyStimulus(0, 1, 1, 1, "t5_clr");
        checkOutput("t5_clr_ec", 32'(ec_a), 0);
        checkOutput("t5_clr_rl", 32'(rl_a), 0);
        checkOutput("t5_clr_alarm", 32'(alarm_a), 0);
        checkOutput("t5_clr_rise", 32'(rise_a), 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 1, "t5_run");
        checkOutput("t5_realarm", 32'(alarm_a), 1);
        applyStimulus(1, 0, 1, 1, "t5_rst");
        checkOutput("t5_rst_rl", 32'(rl_a), 0);
        checkOutput("t5_rst_alarm", 32'(alarm_a), 0);
        checkOutput("t5_rst_ec", 32'(ec_a), 0);

        // Event counter saturation with alternating samples
        for (int k = 0; k < 300; k++) begin
            applyStimulus(0, 0, 1, 1, "t4_hi");
            applyStimulus(0, 0, 1, 0, "t4_lo");
        end
        checkOutput("t4_ec_sat", 32'(ec_a), 255);
        applyStimulus(0, 0, 1, 1, "t4_sat_edge");
        checkOutput("t4_sat_rise", 32'(rise_a), 1);
        checkOutput("t4_sat_ec", 32'(ec_a), 255);

        // Run length saturation
        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 1, 1, "t4_long");
        checkOutput("t4_rl_sat", 32'(rl_a), 15);
        checkOutput("t4_rl_alarm", 32'(alarm_a), 1);
        applyStimulus(0, 0, 1, 0, "t4_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
